// File: rtl/mux_serializer_16_if.sv
// Handshake and mux-facing bundle for mux_serializer_16: parallel load side,
// serial beat side, and the held word / select lines that drive the 16:1 mux.
interface mux_serializer_16_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [15:0] di;
  logic [3:0]  sel;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_last;
  logic        ser_ready;

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, di, sel, ser_out, ser_valid, ser_last
  );

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, di, sel, ser_out, ser_valid, ser_last
  );
endinterface

// File: rtl/mux_serializer_16.sv
// Sequential front-end for the 16:1 mux: holds a word and walks the select lines one beat at a time.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity beat to every frame.
module mux_serializer_16 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_serializer_16_if.slave  bus
);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  localparam logic [3:0] SEL_FIRST = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] SEL_LAST  = MSB_FIRST ? 4'd0  : 4'd15;

`ifdef SERIALIZER_PARITY_EN
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction
`endif

  state_t      state_r;
  logic [15:0] di_r;
  logic [3:0]  sel_r;
  logic        ser_valid_r;
  logic        ser_last_r;

  logic        beat_fire_s;
  logic        final_beat_s;
  logic        load_ready_s;
  logic        load_fire_s;
  logic [3:0]  sel_step_s;
  logic        ser_out_s;

  // Handshake qualifiers; load_ready opens on the final beat so frames run back-to-back.
  always_comb begin
    beat_fire_s  = ser_valid_r && bus.ser_ready;
`ifdef SERIALIZER_PARITY_EN
    final_beat_s = (state_r == PARITY) && beat_fire_s;
`else
    final_beat_s = (state_r == SHIFT) && (sel_r == SEL_LAST) && beat_fire_s;
`endif
    load_ready_s = (state_r == IDLE) || final_beat_s;
    load_fire_s  = bus.load_valid && load_ready_s;
    if (MSB_FIRST) begin
      sel_step_s = sel_r - 4'd1;
    end else begin
      sel_step_s = sel_r + 4'd1;
    end
  end

  // Reference copy of the mux output (or the parity bit on the trailing beat).
  always_comb begin
    ser_out_s = di_r[sel_r];
`ifdef SERIALIZER_PARITY_EN
    if (state_r == PARITY) begin
      ser_out_s = even_parity(di_r);
    end else begin
      ser_out_s = di_r[sel_r];
    end
`endif
  end

  // Frame FSM with registered word, select and beat flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      di_r        <= 16'd0;
      sel_r       <= 4'd0;
      ser_valid_r <= 1'b0;
      ser_last_r  <= 1'b0;
    end else if (load_fire_s) begin
      state_r     <= SHIFT;
      di_r        <= bus.load_data;
      sel_r       <= SEL_FIRST;
      ser_valid_r <= 1'b1;
      ser_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ser_valid_r <= 1'b0;
          ser_last_r  <= 1'b0;
        end
        SHIFT: begin
          if (beat_fire_s) begin
            if (sel_r == SEL_LAST) begin
`ifdef SERIALIZER_PARITY_EN
              // sel stays parked on its final index during the parity beat
              state_r    <= PARITY;
              ser_last_r <= 1'b1;
`else
              state_r     <= IDLE;
              ser_valid_r <= 1'b0;
              ser_last_r  <= 1'b0;
`endif
            end else begin
              sel_r <= sel_step_s;
`ifdef SERIALIZER_PARITY_EN
              ser_last_r <= 1'b0;
`else
              ser_last_r <= (sel_step_s == SEL_LAST);
`endif
            end
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          if (beat_fire_s) begin
            state_r     <= IDLE;
            ser_valid_r <= 1'b0;
            ser_last_r  <= 1'b0;
          end
        end
`endif
        default: begin
          state_r     <= IDLE;
          ser_valid_r <= 1'b0;
          ser_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready_s;
  assign bus.di         = di_r;
  assign bus.sel        = sel_r;
  assign bus.ser_out    = ser_out_s;
  assign bus.ser_valid  = ser_valid_r;
  assign bus.ser_last   = ser_last_r;

endmodule

// File: tb/tb_mux_serializer_16.sv
// Scoreboard bench for mux_serializer_16: LSB-first instance (a) and MSB-first instance (b).
module tb_mux_serializer_16;

`ifdef SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_BEATS = PAR ? 17 : 16;

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  sel;
    logic        bit_v;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_serializer_16_if bus_a ();
  mux_serializer_16_if bus_b ();

  mux_serializer_16 #(.MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_serializer_16 #(.MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  beat_t q_a[$];
  beat_t q_b[$];
  int checks = 0;
  int passed = 0;
  int run_len_a = 0;
  int max_run_a = 0;
  int stall_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cmp_beat(input string tag, input beat_t e, input logic [15:0] di,
                          input logic [3:0] sel, input logic so, input logic last);
    chk({tag, "_sel"}, 32'(sel), 32'(e.sel));
    chk({tag, "_ser_out"}, 32'(so), 32'(e.bit_v));
    chk({tag, "_ser_last"}, 32'(last), 32'(e.last));
    chk({tag, "_di"}, 32'(di), 32'(e.word));
  endtask

  task automatic push_frame(input bit to_b, input logic [15:0] w);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx     = to_b ? 15 - i : i;
      b.word  = w;
      b.sel   = 4'(idx);
      b.bit_v = w[idx];
      b.last  = !PAR && (i == 15);
      if (to_b) q_b.push_back(b); else q_a.push_back(b);
    end
    if (PAR) begin
      b.word  = w;
      b.sel   = to_b ? 4'd0 : 4'd15;
      b.bit_v = ^w;
      b.last  = 1'b1;
      if (to_b) q_b.push_back(b); else q_a.push_back(b);
    end
  endtask

  // Monitor for instance a: compare on every beat fire, and hold-check during stalls.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      run_len_a = 0;
    end else begin
      if (bus_a.ser_valid) run_len_a++; else run_len_a = 0;
      if (run_len_a > max_run_a) max_run_a = run_len_a;
      if (bus_a.ser_valid) begin
        if (q_a.size() == 0) begin
          checks++;
          $display("FAIL a_unexpected_beat: got beat sel=%0d, expected no beat", bus_a.sel);
        end else if (bus_a.ser_ready) begin
          e = q_a.pop_front();
          cmp_beat("a_beat", e, bus_a.di, bus_a.sel, bus_a.ser_out, bus_a.ser_last);
          chk("a_load_ready", 32'(bus_a.load_ready), 32'(e.last));
        end else begin
          stall_a++;
          cmp_beat("a_hold", q_a[0], bus_a.di, bus_a.sel, bus_a.ser_out, bus_a.ser_last);
        end
      end
    end
  end

  // Monitor for instance b (MSB-first, never stalled).
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus_b.ser_valid) begin
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected_beat: got beat sel=%0d, expected no beat", bus_b.sel);
      end else if (bus_b.ser_ready) begin
        e = q_b.pop_front();
        cmp_beat("b_beat", e, bus_b.di, bus_b.sel, bus_b.ser_out, bus_b.ser_last);
        chk("b_load_ready", 32'(bus_b.load_ready), 32'(e.last));
      end
    end
  end

  // Offer a word at a negedge; waits (bounded) for load_ready, fires on the next posedge.
  task automatic offer(input bit to_b, input logic [15:0] w, input bit keep);
    int n = 0;
    if (to_b) begin bus_b.load_valid = 1'b1; bus_b.load_data = w; end
    else      begin bus_a.load_valid = 1'b1; bus_a.load_data = w; end
    while (!(to_b ? bus_b.load_ready : bus_a.load_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL load_timeout: got no load_ready in %0d cycles, expected it", n);
      bus_a.load_valid = 1'b0;
      bus_b.load_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_frame(to_b, w);
      #1;
      if (!keep) begin
        if (to_b) bus_b.load_valid = 1'b0; else bus_a.load_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input bit to_b);
    int n = 0;
    @(negedge clk);
    while ((to_b ? bus_b.ser_valid : bus_a.ser_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(to_b ? "b_idle_reached" : "a_idle_reached", 32'(n < 200), 32'd1);
    chk(to_b ? "b_queue_drained" : "a_queue_drained", to_b ? q_b.size() : q_a.size(), 32'd0);
  endtask

  task automatic wait_sel_a(input logic [3:0] s);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus_a.sel != s && n < 100);
    chk("a_sel_reached", 32'(bus_a.sel), 32'(s));
  endtask

  initial begin
    bus_a.load_valid = 1'b0; bus_a.load_data = 16'h0000; bus_a.ser_ready = 1'b1;
    bus_b.load_valid = 1'b0; bus_b.load_data = 16'h0000; bus_b.ser_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_di", 32'(bus_a.di), 32'h0);
    chk("rst_sel", 32'(bus_a.sel), 32'h0);
    chk("rst_ser_valid", 32'(bus_a.ser_valid), 32'h0);
    chk("rst_ser_last", 32'(bus_a.ser_last), 32'h0);
    chk("rst_load_ready", 32'(bus_a.load_ready), 32'h1);
    chk("rst_b_sel", 32'(bus_b.sel), 32'h0);
    chk("rst_b_load_ready", 32'(bus_b.load_ready), 32'h1);

    // LSB-first frame: expect 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    offer(1'b0, 16'hA5C3, 1'b0);
    wait_idle(1'b0);

    // MSB-first frame: 1, fourteen 0s, 1
    @(negedge clk);
    offer(1'b1, 16'h8001, 1'b0);
    wait_idle(1'b1);

    // Backpressure for 3 cycles at sel=4
    @(negedge clk);
    stall_a = 0;
    offer(1'b0, 16'h00F0, 1'b0);
    wait_sel_a(4'd4);
    bus_a.ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus_a.ser_ready = 1'b1;
    wait_idle(1'b0);
    chk("a_stall_cycles", 32'(stall_a), 32'd3);

    // Back-to-back frames with load_valid held
    @(negedge clk);
    max_run_a = 0;
    offer(1'b0, 16'hFFFF, 1'b1);
    @(negedge clk);
    offer(1'b0, 16'h0000, 1'b0);
    wait_idle(1'b0);
    chk("a_b2b_run", 32'(max_run_a), 32'(2 * FRAME_BEATS));

    // Parity words (plain 16-beat frames when parity is not compiled in)
    @(negedge clk);
    offer(1'b0, 16'h0001, 1'b0);
    wait_idle(1'b0);
    @(negedge clk);
    offer(1'b0, 16'h0003, 1'b0);
    wait_idle(1'b0);

    // Reset mid-frame at sel=7
    @(negedge clk);
    offer(1'b0, 16'h1234, 1'b0);
    wait_sel_a(4'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ser_valid", 32'(bus_a.ser_valid), 32'h0);
    chk("mid_rst_sel", 32'(bus_a.sel), 32'h0);
    chk("mid_rst_di", 32'(bus_a.di), 32'h0);
    chk("mid_rst_ser_last", 32'(bus_a.ser_last), 32'h0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_load_ready", 32'(bus_a.load_ready), 32'h1);
    chk("post_rst_ser_valid", 32'(bus_a.ser_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux_serializer_16.md
# mux_serializer_16

Sequential front-end for the 16:1 gate-level multiplexer. It captures a 16-bit parallel word and steps the 4-bit mux select through all 16 positions, one bit per accepted beat. It presents the held word and select lines for the mux stage to consume, along with an internally resolved serial bit. Parallel loads use a valid/ready handshake; the serial side uses valid/ready with backpressure.

## Interface
Parameters:
- MSB_FIRST, default 0, bit order: 0 sends index 0 through 15; 1 sends index 15 through 0.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  a parallel word is offered.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  16  parallel word.
- di  output  16  held word; wired to the mux data inputs.
- sel  output  4  current bit index; sel[0..3] drive mux s0..s3.
- ser_out  output  1  di[sel], resolved internally (reference copy of the mux output).
- ser_valid  output  1  ser_out is a valid beat.
- ser_last  output  1  current beat is the final beat of the frame.
- ser_ready  input  1  downstream accepts the beat.

## Operation
- State: IDLE or SHIFT, plus PARITY when the configuration macro is defined.
- Register reset values: IDLE; di=0; sel=0; ser_valid=0; ser_last=0; load_ready=1 (combinational, derived from IDLE).
- Reset is asynchronous. Asserting rst_n low mid-frame drops the frame immediately. There is no partial completion.
- Load fire: load_valid && load_ready. On a load fire, di<=load_data, state<=SHIFT, and sel<=0 (or 15 when MSB_FIRST=1).
- Beat fire: ser_valid && ser_ready.
- ser_valid is 1 exactly when state is SHIFT or PARITY.
- In SHIFT, a beat fire advances sel by +1 (or -1 when MSB_FIRST=1).
- ser_last=1 when sel is 15 (or 0 when MSB_FIRST=1) and parity is not compiled in.
- A beat fire on the last beat ends the frame and goes to IDLE, or to PARITY when compiled in.
- load_ready=1 in IDLE.
- load_ready is also 1 during a last-beat fire, to allow back-to-back frames. A load fire in that same cycle goes directly to SHIFT with the new word. This gives zero bubble between frames.
- While ser_valid=1 and ser_ready=0, ser_out, sel, di and ser_last are held stable.
- load_data is ignored outside load fires. di changes only on a load fire.
- In IDLE, di and sel keep their last values; ser_out is don't-care.

## Timing
- Load to first beat: ser_valid is asserted the cycle after the load fire.
- Throughput: 1 bit/cycle with ser_ready held at 1.
  - Without parity, a frame takes 16 cycles.
  - With parity, a frame takes 17 cycles.
- sel, di, ser_valid and ser_last are registered.
- ser_out is combinational from di and sel (a 16:1 select). It is valid in the same cycle as sel.
- load_ready depends combinationally on ser_ready during the last beat. Upstream must not make load_valid depend on load_ready.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - After the 16th data beat fires, the block enters PARITY and presents ser_out = even parity (XOR of di).
  - In PARITY, ser_last=1 and sel holds its final value.
  - The back-to-back load window moves to the parity beat.
- SERIALIZER_PARITY_EN undefined: the PARITY state and its logic are absent, and frames are 16 beats.

## Test plan
- Reset and LSB-first frame:
  - Stimulus: rst_n low, then high; load 16'hA5C3 with MSB_FIRST=0 and ser_ready=1.
  - Response: all outputs read zero/IDLE with load_ready=1 after reset.
  - Response: ser_out reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles, sel counts 0..15, and ser_last is high only on beat 16.
- MSB_FIRST=1:
  - Stimulus: load 16'h8001.
  - Response: sel runs 15..0; ser_out reads 1, then fourteen 0s, then 1.
- Backpressure:
  - Stimulus: load 16'h00F0; drop ser_ready for 3 cycles when sel=4.
  - Response: sel=4, ser_out=1 and ser_valid=1 hold for 3 cycles; the frame then completes in 16 beats total.
- Back-to-back:
  - Stimulus: hold load_valid=1 with 16'hFFFF, then 16'h0000; keep ser_ready=1.
  - Response: load_ready pulses on beat 16; the second frame starts the next cycle with no idle gap, giving 32 consecutive valid beats.
- Reset mid-frame:
  - Stimulus: load 16'h1234, then drop rst_n at sel=7.
  - Response: ser_valid=0, sel=0 and di=0 immediately; after release, load_ready=1.
- With SERIALIZER_PARITY_EN defined:
  - Stimulus: load 16'h0001, then 16'h0003.
  - Response: beat 17 gives ser_out=1 and ser_last=1 for the first word, and ser_out=0 for the second.
